mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between instruction fetch (read-only) and the MEM stage (read/write), so the pipeline can run from a unified memory.
- RAM samples address, data and write enable on the rising clock edge. Read data appears on ram_dout one cycle later.
- Grants are combinational; an ungranted requester must stall its stage and hold its request.
- Includes a starvation guard so fetch cannot be locked out by back-to-back loads and stores.

Parameters:
- ADDR_W, 8, word-address width for all address ports.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied cycles after which the fetch port gets forced priority (valid range 1..15).

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request (read).
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  ram_dout holds fetch data for the request granted last cycle.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  ram_dout holds load data for the read granted last cycle.
- rdata  out  DATA_W  equal to ram_dout, shared by both ports, qualified by the rvalid signals.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_dout  in  DATA_W  RAM read data (one-cycle latency).
- if_starved  out  1  fetch wait counter has reached MAX_WAIT.

Behaviour:
- Reset (clear=1, asynchronous):
  - if_gnt, d_gnt, ram_wren, if_rvalid, d_rvalid, if_starved all 0.
  - Wait counter = 0. Round-robin pointer = IF.
  - Grants are forced to 0 while clear is high.
  - A read outstanding at reset produces no rvalid.
- Grant (combinational, one grant per cycle):
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both, if_starved=0: d_gnt=1 (fixed priority, MEM stage is the older instruction).
  - Both, if_starved=1: if_gnt=1.
  - Neither: no grant, ram_wren=0, ram_addr holds its previous registered value.
- RAM drive:
  - Granted port's address goes to ram_addr.
  - ram_din = d_wdata.
  - ram_wren = d_gnt & d_we.
- Read return (registered):
  - if_rvalid <= if_gnt.
  - d_rvalid <= d_gnt & ~d_we.
  - Read latency is exactly 1 cycle after grant.
  - Writes complete at the grant edge and never raise rvalid.
- Wait counter (4-bit, saturating at MAX_WAIT):
  - Increment when if_req & ~if_gnt.
  - Reset to 0 on if_gnt, or when if_req=0.
  - if_starved = (counter == MAX_WAIT), registered.
  - Counter clears on the cycle fetch is granted, so starvation grants last exactly one cycle.
- Requesters must hold req and address stable until the grant.
  - A request dropped before grant is legal and ignored.
  - Address changes while ungranted take effect immediately.
- Simultaneous grant and new request in the same cycle: allowed (fully pipelined, one access per cycle).
- Address width: ram_addr uses the low ADDR_W bits. Wrap-around at 2^ADDR_W is the RAM's concern; the arbiter applies no range check.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - When both ports request, grant goes to the port named by a 1-bit pointer.
  - Pointer flips to the other port after each contended grant.
  - Uncontended grants leave the pointer unchanged.
  - The starvation counter still runs and if_starved still overrides, though it cannot reach MAX_WAIT>=2 under round-robin.
- Undefined: fixed data-priority as described above.

Test Plan:
- Reset mid-read: grant if_req at addr 0x10, assert clear before the next edge -> if_rvalid stays 0, all outputs 0 during clear.
- Solo fetch: if_req=1 at addr 0x05, RAM[5]=0xDEADBEEF -> if_gnt=1 same cycle, next cycle if_rvalid=1 and rdata=0xDEADBEEF.
- Store then load: d_we=1 to addr 0x20 with 0x1234, then d_we=0 to addr 0x20 -> ram_wren=1 in cycle 1 only, d_rvalid=1 in cycle 3 with rdata=0x1234, no d_rvalid for the store.
- Contention: if_req and d_req both held high, MAX_WAIT=4 -> d_gnt for 4 cycles, if_starved=1, then if_gnt for 1 cycle, pattern repeats every 5 cycles.
- Round robin (ARB_ROUND_ROBIN_EN): both ports request continuously -> grants alternate IF, D, IF, D starting with IF after reset.
- Dropped request: if_req high 2 cycles denied, then low -> counter back to 0, if_starved stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port synchronous RAM between the instruction-fetch port
//   (read-only) and the MEM-stage data port (read/write). Each cycle, one
//   requester is granted combinationally and its access is driven to the RAM.
//   The RAM returns read data one cycle after the grant. A wait counter keeps
//   fetch from being starved by continuous data traffic.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, contended cycles alternate between the
//                        two ports using a 1-bit pointer. When undefined, the
//                        data port wins contention unless fetch is starved.
//
// Ports:
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-high reset
//   if_req     in   fetch read request
//   if_addr    in   fetch word address
//   if_gnt     out  fetch request accepted this cycle
//   if_rvalid  out  rdata holds fetch data for last cycle's fetch grant
//   d_req      in   data request
//   d_we       in   1 = write, 0 = read
//   d_addr     in   data word address
//   d_wdata    in   store data
//   d_gnt      out  data request accepted this cycle
//   d_rvalid   out  rdata holds load data for last cycle's data read grant
//   rdata      out  RAM read data, shared by both ports
//   ram_addr   out  RAM address
//   ram_din    out  RAM write data
//   ram_wren   out  RAM write enable
//   ram_dout   in   RAM read data (one-cycle latency)
//   if_starved out  fetch wait counter has reached MAX_WAIT
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              if_starved
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]        waitCnt_q, waitCnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              ifRvalid_q;
    logic              dRvalid_q;
    logic              ifWins;

`ifdef ARB_ROUND_ROBIN_EN
    typedef enum logic {
        PTR_IF = 1'b0,
        PTR_D  = 1'b1
    } rr_ptr_t;

    rr_ptr_t rrPtr_q, rrPtr_d;
`endif

    assign if_starved = (waitCnt_q == MAX_WAIT_C);

    // Contention winner: a starved fetch always wins; otherwise either the
    // round-robin pointer decides, or the data port (older instruction) wins.
    always_comb begin
        ifWins = if_starved;
`ifdef ARB_ROUND_ROBIN_EN
        if (rrPtr_q == PTR_IF) begin
            ifWins = 1'b1;
        end
`endif
    end

    // Grants are suppressed while clear is high so nothing reaches the RAM.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!clear) begin
            if (if_req && d_req) begin
                if_gnt = ifWins;
                d_gnt  = ~ifWins;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    // With no grant the address bus parks on the last driven address.
    always_comb begin
        ram_addr = addr_q;
        if (if_gnt) begin
            ram_addr = if_addr;
        end else if (d_gnt) begin
            ram_addr = d_addr;
        end
    end

    assign ram_din  = d_wdata;
    assign ram_wren = d_gnt & d_we;
    assign rdata    = ram_dout;

    // The counter saturates at MAX_WAIT and clears whenever fetch is granted
    // or stops asking, so a starvation grant lasts exactly one cycle.
    always_comb begin
        waitCnt_d = 4'd0;
        if (if_req && !if_gnt) begin
            waitCnt_d = (waitCnt_q == MAX_WAIT_C) ? waitCnt_q : waitCnt_q + 4'd1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Only contended cycles move the pointer; it then names the loser.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (if_req && d_req && (if_gnt || d_gnt)) begin
            rrPtr_d = if_gnt ? PTR_D : PTR_IF;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rrPtr_q <= PTR_IF;
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end
`endif

    // Registered state: wait counter, parked address and read-return flags.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            waitCnt_q  <= 4'd0;
            addr_q     <= '0;
            ifRvalid_q <= 1'b0;
            dRvalid_q  <= 1'b0;
        end else begin
            waitCnt_q  <= waitCnt_d;
            addr_q     <= ram_addr;
            ifRvalid_q <= if_gnt;
            dRvalid_q  <= d_gnt & ~d_we;
        end
    end

    assign if_rvalid = ifRvalid_q;
    assign d_rvalid  = dRvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A behavioural RAM drives ram_dout;
// a separate reference memory and a cycle-level model of the arbitration
// rules predict grants, RAM drive, read returns and starvation.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clock;
    logic              clear;
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic              ifGnt;
    logic              ifRvalid;
    logic              dReq;
    logic              dWe;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dWdata;
    logic              dGnt;
    logic              dRvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramDin;
    logic              ramWren;
    logic [DATA_W-1:0] ramDout;
    logic              ifStarved;

    int checkCount = 0;
    int errorCount = 0;
    int ifGntSeen  = 0;

    // Reference model state
    logic [DATA_W-1:0] refMem [256];
    logic [DATA_W-1:0] ramArr [256];
    int                waitCnt;
    logic              expIfRv;
    logic              expDRv;
    logic [DATA_W-1:0] expRdata;
    logic              rrPtr;
    logic [ADDR_W-1:0] lastAddr;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .if_req    (ifReq),
        .if_addr   (ifAddr),
        .if_gnt    (ifGnt),
        .if_rvalid (ifRvalid),
        .d_req     (dReq),
        .d_we      (dWe),
        .d_addr    (dAddr),
        .d_wdata   (dWdata),
        .d_gnt     (dGnt),
        .d_rvalid  (dRvalid),
        .rdata     (rdata),
        .ram_addr  (ramAddr),
        .ram_din   (ramDin),
        .ram_wren  (ramWren),
        .ram_dout  (ramDout),
        .if_starved(ifStarved)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [DATA_W-1:0] initWord(input int idx);
        return 32'(idx) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
    endfunction

    // Behavioural synchronous RAM: read-before-write, one-cycle latency.
    initial begin
        for (int i = 0; i < 256; i++) begin
            ramArr[i] = initWord(i);
        end
        forever begin
            @(posedge clock);
            if (ramWren) begin
                ramArr[ramAddr] <= ramDin;
            end
            ramDout <= ramArr[ramAddr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        waitCnt  = 0;
        expIfRv  = 1'b0;
        expDRv   = 1'b0;
        expRdata = '0;
        rrPtr    = 1'b0;
        lastAddr = '0;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the
    // model past the rising edge.
    task automatic applyStimulus(input logic ir, input logic [ADDR_W-1:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [ADDR_W-1:0] da,
                                 input logic [DATA_W-1:0] dwd);
        logic              eIf;
        logic              eD;
        logic              starvedE;
        logic              ifWinsE;
        logic [ADDR_W-1:0] eAddr;
        @(negedge clock);
        ifReq  = ir;
        ifAddr = ia;
        dReq   = dr;
        dWe    = dw;
        dAddr  = da;
        dWdata = dwd;
        #1;
        starvedE = (waitCnt == MAX_WAIT);
        ifWinsE  = starvedE || (RR_EN && rrPtr == 1'b0);
        eIf      = ir && (!dr || ifWinsE);
        eD       = dr && !eIf;
        eAddr    = eIf ? ia : (eD ? da : lastAddr);

        checkOutput("if_gnt", 32'(ifGnt), 32'(eIf));
        checkOutput("d_gnt", 32'(dGnt), 32'(eD));
        checkOutput("ram_wren", 32'(ramWren), 32'(eD && dw));
        checkOutput("ram_addr", 32'(ramAddr), 32'(eAddr));
        checkOutput("ram_din", ramDin, dwd);
        checkOutput("if_rvalid", 32'(ifRvalid), 32'(expIfRv));
        checkOutput("d_rvalid", 32'(dRvalid), 32'(expDRv));
        checkOutput("if_starved", 32'(ifStarved), 32'(starvedE));
        if (expIfRv || expDRv) begin
            checkOutput("rdata", rdata, expRdata);
        end
        if (ifGnt) begin
            ifGntSeen++;
        end

        @(posedge clock);
        expIfRv  = eIf;
        expDRv   = eD && !dw;
        expRdata = refMem[eAddr];
        if (eD && dw) begin
            refMem[da] = dwd;
        end
        if (ir && !eIf) begin
            waitCnt = (waitCnt >= MAX_WAIT) ? MAX_WAIT : waitCnt + 1;
        end else begin
            waitCnt = 0;
        end
        if (ir && dr) begin
            rrPtr = eIf ? 1'b1 : 1'b0;
        end
        lastAddr = eAddr;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int contendedIf;
        for (int i = 0; i < 256; i++) begin
            refMem[i] = initWord(i);
        end
        resetModel();
        clear  = 1'b1;
        ifReq  = 1'b0;
        ifAddr = '0;
        dReq   = 1'b0;
        dWe    = 1'b0;
        dAddr  = '0;
        dWdata = '0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        checkOutput("rst_if_gnt", 32'(ifGnt), 32'd0);
        checkOutput("rst_d_gnt", 32'(dGnt), 32'd0);
        checkOutput("rst_ram_wren", 32'(ramWren), 32'd0);
        checkOutput("rst_if_rvalid", 32'(ifRvalid), 32'd0);
        checkOutput("rst_d_rvalid", 32'(dRvalid), 32'd0);
        checkOutput("rst_if_starved", 32'(ifStarved), 32'd0);
        checkOutput("rst_ram_addr", 32'(ramAddr), 32'd0);
        clear = 1'b0;

        // Solo fetch of a known word
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 8'h05, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, '0, '0);
        checkOutput("solo_if_rvalid", 32'(ifRvalid), 32'd1);
        checkOutput("solo_rdata", rdata, 32'hDEAD_BEEF);
        idleCycle();

        // Store then load the same address
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 8'h20, 32'h0000_1234);
        checkOutput("store_no_rvalid", 32'(dRvalid), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h20, '0);
        checkOutput("load_d_rvalid", 32'(dRvalid), 32'd1);
        checkOutput("load_rdata", rdata, 32'h0000_1234);
        idleCycle();

        // Sustained contention
        ifGntSeen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, 8'h80 + 8'(i), '0);
        end
        contendedIf = RR_EN ? 5 : 2;
        checkOutput("contention_if_grants", 32'(ifGntSeen), 32'(contendedIf));
        idleCycle();

        // Fetch denied twice, then withdrawn
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 8'h12, '0);
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 8'h13, '0);
        applyStimulus(1'b0, 8'h11, 1'b1, 1'b0, 8'h14, '0);
        checkOutput("drop_starved", 32'(ifStarved), 32'd0);
        idleCycle();

        // Randomized traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)),
                          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), $urandom);
        end
        idleCycle();

        // Reset arriving while a fetch read is outstanding
        @(negedge clock);
        ifReq  = 1'b1;
        ifAddr = 8'h10;
        dReq   = 1'b0;
        dWe    = 1'b0;
        #1;
        checkOutput("midrst_pre_gnt", 32'(ifGnt), 32'd1);
        #2;
        clear = 1'b1;
        #1;
        checkOutput("midrst_if_gnt", 32'(ifGnt), 32'd0);
        checkOutput("midrst_d_gnt", 32'(dGnt), 32'd0);
        checkOutput("midrst_ram_wren", 32'(ramWren), 32'd0);
        checkOutput("midrst_if_starved", 32'(ifStarved), 32'd0);
        checkOutput("midrst_ram_addr", 32'(ramAddr), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("midrst_if_rvalid", 32'(ifRvalid), 32'd0);
        checkOutput("midrst_d_rvalid", 32'(dRvalid), 32'd0);
        @(negedge clock);
        ifReq = 1'b0;
        clear = 1'b0;
        resetModel();

        // Post-reset traffic, including contention from a fresh pointer
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), $urandom);
        end
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
